register_bank32: RTL and testbench
==================================

# register_bank32

32 x 32-bit integer register storage with a single write-back port and a per-register pending-write scoreboard. It sits directly upstream of the 32:1 read-port mux. It drives all 32 register values as one flattened bus, sliced into the mux's In0..In31 inputs, and exports busy bits so the decode stage can stall on read-after-write hazards. Register x0 is hardwired to zero.

## Interface

Parameters:
- XLEN, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (x0..x31)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- RegWrite  input  1  write-back enable
- WriteRegister  input  5  write-back destination index
- WriteData  input  32  write-back data
- IssueValid  input  1  an instruction with a destination register issues this cycle
- IssueRegister  input  5  destination index of the issuing instruction
- RegOut  output  1024  flattened register values; bits [32*i+31:32*i] hold register i; feeds read mux In0..In31
- Busy  output  32  bit i set means register i has an outstanding write
- PendingCount  output  6  number of set Busy bits

## Operation

- **Write:** on a rising edge with Reset=0, RegWrite=1 and WriteRegister!=0, register[WriteRegister] <= WriteData.
- **x0:** writes to x0 are dropped. RegOut[31:0] is constant 0.
- **Issue:** on an edge with IssueValid=1 and IssueRegister!=0, Busy[IssueRegister] <= 1.
  - Issue to x0 is ignored; Busy[0] is always 0.
- **Clear:** on an edge with RegWrite=1 and WriteRegister!=0, Busy[WriteRegister] <= 0.
- **Same edge, same register (issue and write-back):** the set wins. Busy stays 1 because the new producer is still outstanding, and the data write still occurs.
- **Same edge, different registers:** the set and the clear apply independently.
- **Write-back to a non-busy register:** legal. Data is written and Busy stays 0.
- **PendingCount:** registered popcount of the next-state Busy vector, so it always equals popcount(Busy) in the same cycle. Range 0..31; it never wraps.
- **Reset:** all registers, Busy and PendingCount go to 0 on the edge where Reset=1. Reset overrides any simultaneous write or issue.
  - A mid-operation reset discards all pending state; no busy bit survives.

## Timing

- Write latency 1: data written at edge N is visible on RegOut after edge N.
- Busy set and clear both take effect after the edge; Busy, PendingCount and RegOut are all registered.
- No combinational path from inputs to outputs, unless the bypass below is compiled in.
- Reset values: RegOut = 0, Busy = 0, PendingCount = 0.
- No handshake back-pressure; every input is consumed in the cycle it is presented.

## Configuration

- **REGBANK_WB_BYPASS_EN defined:** write-first behaviour.
  - While RegWrite=1 and WriteRegister!=0, the RegOut slice for WriteRegister combinationally presents WriteData in the same cycle.
  - The read mux therefore sees write-back data without a one-cycle gap.
  - Busy is unaffected and remains registered.
- **REGBANK_WB_BYPASS_EN undefined:** RegOut is purely registered, and new data appears one cycle after the write edge.

## Structure

- Package regbank_pkg holds:
  - constants XLEN_C=32, NUM_REGS_C=32, REG_ADDR_W=5
  - typedefs reg_addr_t (logic [4:0]) and word_t (logic [31:0])
  - function onehot5to32 for the decoders
- One sub-module, regbank_scoreboard: the Busy vector, the set/clear priority logic and the PendingCount register.
- The storage array, write decoder and optional bypass stay in register_bank32.

## Test plan

- **Reset:** write x5=0xDEADBEEF, then assert Reset for one cycle -> RegOut slice 5 = 0, Busy = 0, PendingCount = 0 on the next cycle.
- **Write/read:** write x1=0x00000011 and x31=0xFFFFFFFF -> both slices hold those values one cycle later. Write x0=0x12345678 -> slice 0 stays 0.
- **Scoreboard:**
  - Issue x3, then x7 -> Busy = 0x00000088, PendingCount = 2.
  - Write back x3 -> Busy = 0x00000080, PendingCount = 1.
- **Simultaneous same register:** with Busy[9]=1, issue x9 and write back x9=0xA5A5A5A5 on the same edge -> Busy[9] stays 1, slice 9 = 0xA5A5A5A5.
- **Saturation and x0:**
  - Issue x1..x31 on consecutive cycles -> PendingCount = 31, Busy = 0xFFFFFFFE.
  - Issue x0 -> no change.
- **Bypass:** write x4=0xCAFEF00D with the macro defined -> slice 4 shows 0xCAFEF00D in the same cycle as RegWrite. With the macro undefined -> the value appears one cycle later.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants, types and the 5-to-32 decoder used by the register bank
// and its busy-bit scoreboard.
package regbank_pkg;

  localparam int XLEN_C     = 32;
  localparam int NUM_REGS_C = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN_C-1:0]     word_t;

  function automatic logic [NUM_REGS_C-1:0] onehot5to32(input reg_addr_t addr);
    logic [NUM_REGS_C-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register pending-write tracker: busy bits set on issue, cleared on
// write-back, with a registered popcount that always matches the busy vector.
module regbank_scoreboard
  import regbank_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_en_i,
  input  reg_addr_t             set_addr_i,
  input  logic                  clr_en_i,
  input  reg_addr_t             clr_addr_i,
  output logic [NUM_REGS_C-1:0] busy_o,
  output logic [5:0]            pending_o
);

  logic [NUM_REGS_C-1:0] busy_q, busy_d;
  logic [NUM_REGS_C-1:0] set_mask, clr_mask;
  logic [5:0]            pending_q, pending_d;

  // x0 never becomes busy; applying the set after the clear makes a new
  // producer win over a same-edge write-back to the same register.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    pending_d = '0;
    if (set_en_i && (set_addr_i != '0)) set_mask = onehot5to32(set_addr_i);
    if (clr_en_i && (clr_addr_i != '0)) clr_mask = onehot5to32(clr_addr_i);
    busy_d = (busy_q & ~clr_mask) | set_mask;
    for (int i = 0; i < NUM_REGS_C; i++) begin
      pending_d = pending_d + {5'b0, busy_d[i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign busy_o    = busy_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/register_bank32.sv
// 32 x 32-bit register file with one write-back port, hardwired-zero x0 and a
// busy-bit scoreboard. Define REGBANK_WB_BYPASS_EN for write-first read-out.
module register_bank32
  import regbank_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     RegWrite,
  input  logic [4:0]               WriteRegister,
  input  logic [XLEN-1:0]          WriteData,
  input  logic                     IssueValid,
  input  logic [4:0]               IssueRegister,
  output logic [NUM_REGS*XLEN-1:0] RegOut,
  output logic [NUM_REGS-1:0]      Busy,
  output logic [5:0]               PendingCount
);

  // Inputs are consumed every cycle; there is no ready/back-pressure path.
  word_t regs_q [1:NUM_REGS-1];
  word_t regs_d [1:NUM_REGS-1];
  logic  wr_en;

  assign wr_en = RegWrite && (WriteRegister != '0);

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) regs_d[WriteRegister] = WriteData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    RegOut = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      RegOut[i*XLEN +: XLEN] = regs_q[i];
    end
`ifdef REGBANK_WB_BYPASS_EN
    // Write-first: the slice being written shows the incoming data this cycle.
    if (wr_en) RegOut[int'(WriteRegister)*XLEN +: XLEN] = WriteData;
`else
`endif
  end

  regbank_scoreboard u_scoreboard (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .set_en_i   (IssueValid),
    .set_addr_i (IssueRegister),
    .clr_en_i   (RegWrite),
    .clr_addr_i (WriteRegister),
    .busy_o     (Busy),
    .pending_o  (PendingCount)
  );

endmodule

// File: tb/tb_register_bank32.sv
// Self-checking bench for register_bank32 against a behavioural model of the
// register contents and the set of registers with outstanding writes.
module tb_register_bank32;

  logic          Clk;
  logic          Reset;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic          IssueValid;
  logic [4:0]    IssueRegister;
  logic [1023:0] RegOut;
  logic [31:0]   Busy;
  logic [5:0]    PendingCount;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] exp_q [$];

  register_bank32 dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .IssueValid    (IssueValid),
    .IssueRegister (IssueRegister),
    .RegOut        (RegOut),
    .Busy          (Busy),
    .PendingCount  (PendingCount)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- model helpers ----------------
  function automatic void model_edge();
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (RegWrite && WriteRegister != 0) begin
        m_regs[WriteRegister] = WriteData;
        m_busy[WriteRegister] = 1'b0;
      end
      if (IssueValid && IssueRegister != 0) m_busy[IssueRegister] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [5:0] model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return 6'(n);
  endfunction

  function automatic logic [1023:0] model_regout();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = (i == 0) ? 32'h0 : m_regs[i];
`ifdef REGBANK_WB_BYPASS_EN
    if (RegWrite && WriteRegister != 0) v[int'(WriteRegister)*32 +: 32] = WriteData;
`endif
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic go_idle();
    Reset      = 1'b0;
    RegWrite   = 1'b0;
    IssueValid = 1'b0;
  endtask

  // Present one cycle of inputs, take the edge, return to idle at negedge.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic iv, input logic [4:0] ia);
    Reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    IssueValid = iv; IssueRegister = ia;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    go_idle();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (RegOut !== 1024'h0) begin
      errors++; $display("FAIL reset_regout: got %h expected 0", RegOut[255:0]);
    end
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5);
    checks++;
    if (RegOut[191:160] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pre_reset_x5: got %h expected deadbeef", RegOut[191:160]);
    end
    do_reset();
    checks++;
    if (RegOut[191:160] !== 32'h0) begin
      errors++; $display("FAIL reset_x5: got %h expected 0", RegOut[191:160]);
    end
    checks++;
    if (Busy !== 32'h0 || PendingCount !== 6'd0) begin
      errors++; $display("FAIL reset_busy: got busy=%h cnt=%0d expected 0/0", Busy, PendingCount);
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 5'd1, 32'h00000011, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
    checks++;
    if (RegOut[63:32] !== 32'h00000011) begin
      errors++; $display("FAIL write_x1: got %h expected 00000011", RegOut[63:32]);
    end
    checks++;
    if (RegOut[1023:992] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL write_x31: got %h expected ffffffff", RegOut[1023:992]);
    end
    checks++;
    if (RegOut[31:0] !== 32'h0) begin
      errors++; $display("FAIL write_x0: got %h expected 0", RegOut[31:0]);
    end
    checks++;
    if (RegOut !== model_regout()) begin
      errors++; $display("FAIL write_all: got %h expected %h", RegOut[255:0], model_regout() >> 0);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checks++;
    if (Busy !== 32'h00000088 || PendingCount !== 6'd2) begin
      errors++; $display("FAIL issue_3_7: got busy=%h cnt=%0d expected 00000088/2", Busy, PendingCount);
    end
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    checks++;
    if (Busy !== 32'h00000080 || PendingCount !== 6'd1) begin
      errors++; $display("FAIL wb_3: got busy=%h cnt=%0d expected 00000080/1", Busy, PendingCount);
    end
    drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    checks++;
    if (Busy !== 32'h00000080 || RegOut[95:64] !== 32'h22) begin
      errors++; $display("FAIL wb_nonbusy: got busy=%h x2=%h expected 00000080/22", Busy, RegOut[95:64]);
    end
  endtask

  task automatic test_same_reg();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9);
    checks++;
    if (Busy[9] !== 1'b1 || RegOut[319:288] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL same_reg: got busy9=%b x9=%h expected 1/a5a5a5a5", Busy[9], RegOut[319:288]);
    end
    drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd12);
    checks++;
    if (Busy !== 32'h00001200 || PendingCount !== 6'd2) begin
      errors++; $display("FAIL diff_reg: got busy=%h cnt=%0d expected 00001200/2", Busy, PendingCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 1; r < 32; r++) drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r));
    checks++;
    if (Busy !== 32'hFFFFFFFE || PendingCount !== 6'd31) begin
      errors++; $display("FAIL saturate: got busy=%h cnt=%0d expected fffffffe/31", Busy, PendingCount);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    checks++;
    if (Busy !== 32'hFFFFFFFE || PendingCount !== 6'd31) begin
      errors++; $display("FAIL issue_x0: got busy=%h cnt=%0d expected fffffffe/31", Busy, PendingCount);
    end
    drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6);
    checks++;
    if (Busy !== 32'h0 || PendingCount !== 6'd0 || RegOut[223:192] !== 32'h0) begin
      errors++; $display("FAIL reset_override: got busy=%h cnt=%0d x6=%h expected 0/0/0", Busy, PendingCount, RegOut[223:192]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_now;
    Reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'hCAFEF00D;
    IssueValid = 1'b0; IssueRegister = 5'd0;
`ifdef REGBANK_WB_BYPASS_EN
    exp_now = 32'hCAFEF00D;
`else
    exp_now = m_regs[4];
`endif
    #2;
    checks++;
    if (RegOut[159:128] !== exp_now) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", RegOut[159:128], exp_now);
    end
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    go_idle();
    checks++;
    if (RegOut[159:128] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bypass_next_cycle: got %h expected cafef00d", RegOut[159:128]);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_busy, e_cnt;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      exp_q.push_back(model_busy_vec());
      exp_q.push_back({26'h0, model_count()});
      e_busy = exp_q.pop_front();
      e_cnt  = exp_q.pop_front();
      checks++;
      if (Busy !== e_busy || {26'h0, PendingCount} !== e_cnt) begin
        errors++; $display("FAIL rand_busy[%0d]: got busy=%h cnt=%0d expected %h/%0d", n, Busy, PendingCount, e_busy, e_cnt);
      end
      checks++;
      if (RegOut !== model_regout()) begin
        errors++; $display("FAIL rand_regout[%0d]: mismatched register contents", n);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    go_idle();
    WriteRegister = '0; WriteData = '0; IssueRegister = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    @(negedge Clk);
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_reg();
    test_saturation();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
